imem_fetch_unit: RTL

- Instruction-memory responder that sources `icache_instr` for `core`.
- Replaces the hand-timed stimulus driver with a loadable program store and a sequential fetch engine.
- Holds a word-addressed program RAM with a configurable read latency, prefetches into a small queue, and presents one instruction per cycle to the core.
- Supports stall, PC redirect and end-of-program (all-zero word) detection.

---
 rtl/imem_fetch_unit_if.sv | 38 +++
 rtl/imem_fetch_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_unit_if.sv
// Program-load, control and instruction-delivery bus between the core side and imem_fetch_unit.
// Perf counter outputs exist only when FETCH_PERF_CNT_EN is defined.
interface imem_fetch_unit_if #(
    parameter int ADDR_W = 6
);
    logic              load_we;
    logic [ADDR_W-1:0] load_addr;
    logic [31:0]       load_data;
    logic              start;
    logic              stall;
    logic              redirect;
    logic [31:0]       redirect_pc;
    logic [31:0]       icache_instr;
    logic              instr_valid;
    logic [31:0]       instr_pc;
    logic              busy;
    logic              done;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]       perf_delivered;
    logic [31:0]       perf_bubbles;
`endif

    modport master (
        output load_we, load_addr, load_data, start, stall, redirect, redirect_pc,
`ifdef FETCH_PERF_CNT_EN
        input  perf_delivered, perf_bubbles,
`endif
        input  icache_instr, instr_valid, instr_pc, busy, done
    );

    modport slave (
        input  load_we, load_addr, load_data, start, stall, redirect, redirect_pc,
`ifdef FETCH_PERF_CNT_EN
        output perf_delivered, perf_bubbles,
`endif
        output icache_instr, instr_valid, instr_pc, busy, done
    );
endinterface

// File: rtl/imem_fetch_unit.sv
// Loadable program RAM with a LAT-stage read pipe, prefetch queue and one-per-cycle delivery to the core.
// Optional delivery/bubble counters are compiled in with FETCH_PERF_CNT_EN.
module imem_fetch_unit #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6,
    parameter int LAT    = 1,
    parameter int QDEPTH = 4
) (
    input logic              clk,
    input logic              rst,
    imem_fetch_unit_if.slave fetch_if
);
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] PC_END = 32'(DEPTH * 4);
    localparam int          PW     = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int          CW     = $clog2(QDEPTH + LAT + 1) + 1;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_HALT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q;
    logic [31:0] instr_q, ipc_q;
    logic        valid_q, busy_q, done_q;

    logic [31:0]            mem [DEPTH];
    logic [31:0]            ram_rd_q;
    logic                   s0_oor_q;
    logic [LAT-1:0]         pipe_vld_q;
    logic [31:0]            pipe_pc_q [LAT];
    logic [LAT-1:0][31:0]   dchain;

    logic [31:0]   q_data_q [QDEPTH];
    logic [31:0]   q_pc_q   [QDEPTH];
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] q_count_q;

    logic          idle_like, active, start_go, redirect_go, wr_en;
    logic          issue, oor, push, pop, ret_valid, ret_zero;
    logic [CW-1:0] inflight, occupancy;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign idle_like   = (state_q == S_IDLE) || (state_q == S_HALT);
    assign active      = (state_q == S_FETCH) || (state_q == S_DRAIN);
    assign start_go    = fetch_if.start && idle_like;
    assign redirect_go = fetch_if.redirect && active;
    assign wr_en       = fetch_if.load_we && idle_like && !rst;
    assign ret_valid   = pipe_vld_q[LAT-1];
    assign ret_zero    = ret_valid && (dchain[LAT-1] == 32'h0);
    assign push        = ret_valid && !ret_zero && !redirect_go;
    assign pop         = !fetch_if.stall && !redirect_go && (q_count_q != '0);
    assign oor         = (pc_q >= PC_END);

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) begin
            inflight = inflight + CW'(pipe_vld_q[i]);
        end
    end

    // Credit check uses the post-pop queue count so a full LAT+1 window still sustains one issue per cycle.
    assign occupancy = q_count_q + inflight - CW'(pop);
    assign issue     = (state_q == S_FETCH) && !redirect_go && !ret_zero && (occupancy < CW'(QDEPTH));

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[fetch_if.load_addr] <= fetch_if.load_data;
        end
        if (issue && !oor) begin
            ram_rd_q <= mem[pc_q[ADDR_W+1:2]];
        end
    end

    assign dchain[0] = s0_oor_q ? 32'h0 : ram_rd_q;

    generate
        for (genvar gi = 1; gi < LAT; gi++) begin : g_dly
            logic [31:0] data_q;
            always_ff @(posedge clk) begin
                data_q <= dchain[gi-1];
            end
            assign dchain[gi] = data_q;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (push) begin
            q_data_q[wr_ptr_q] <= dchain[LAT-1];
            q_pc_q[wr_ptr_q]   <= pipe_pc_q[LAT-1];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_HALT: if (fetch_if.start) state_d = S_FETCH;
            S_FETCH:        if (!redirect_go && ret_zero) state_d = S_DRAIN;
            S_DRAIN: begin
                if (redirect_go) state_d = S_FETCH;
                else if (q_count_q == '0 && inflight == '0) state_d = S_HALT;
            end
            default:        state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pc_q       <= '0;
            s0_oor_q   <= 1'b0;
            pipe_vld_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                pipe_pc_q[i] <= '0;
            end
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            q_count_q  <= '0;
            instr_q    <= NOP;
            valid_q    <= 1'b0;
            ipc_q      <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d == S_FETCH) || (state_d == S_DRAIN);
            if (start_go) done_q <= 1'b0;
            else if (state_q == S_DRAIN && state_d == S_HALT) done_q <= 1'b1;

            if (start_go) pc_q <= '0;
            else if (redirect_go) pc_q <= fetch_if.redirect_pc & ~32'h3;
            else if (issue) pc_q <= pc_q + 32'd4;
            s0_oor_q <= oor;

            for (int i = LAT - 1; i > 0; i--) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_pc_q[i]  <= pipe_pc_q[i-1];
            end
            pipe_vld_q[0] <= issue;
            pipe_pc_q[0]  <= pc_q;
            // A returned zero word ends the program: everything younger is discarded.
            if (redirect_go || ret_zero) pipe_vld_q <= '0;

            if (redirect_go) begin
                rd_ptr_q  <= '0;
                wr_ptr_q  <= '0;
                q_count_q <= '0;
            end else begin
                if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
                if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
                q_count_q <= q_count_q + CW'(push) - CW'(pop);
            end

            if (redirect_go) begin
                instr_q <= NOP;
                valid_q <= 1'b0;
            end else if (!fetch_if.stall) begin
                if (pop) begin
                    instr_q <= q_data_q[rd_ptr_q];
                    ipc_q   <= q_pc_q[rd_ptr_q];
                    valid_q <= 1'b1;
                end else begin
                    instr_q <= NOP;
                    valid_q <= 1'b0;
                end
            end
        end
    end

    assign fetch_if.icache_instr = instr_q;
    assign fetch_if.instr_valid  = valid_q;
    assign fetch_if.instr_pc     = ipc_q;
    assign fetch_if.busy         = busy_q;
    assign fetch_if.done         = done_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_del_q, perf_bub_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_del_q <= '0;
            perf_bub_q <= '0;
        end else if (start_go) begin
            perf_del_q <= '0;
            perf_bub_q <= '0;
        end else begin
            if (pop && perf_del_q != '1) perf_del_q <= perf_del_q + 32'd1;
            if (busy_q && !fetch_if.stall && q_count_q == '0 && perf_bub_q != '1)
                perf_bub_q <= perf_bub_q + 32'd1;
        end
    end

    assign fetch_if.perf_delivered = perf_del_q;
    assign fetch_if.perf_bubbles   = perf_bub_q;
`endif
endmodule
